// File: rtl/fp_mul_pipe.sv
// Three-stage valid/ready floating-point multiplier with round-to-nearest-even.
// Subnormal operands and underflowing results are flushed to signed zero.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic                 out_nan,
    output logic                 out_inf,
    output logic                 out_zero
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0]    BIAS   = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] EMAX   = '1;
    localparam logic [XW-1:0]    EMAX_X = {2'b00, EMAX};

    logic adv;

    // Stage 1 registers
    logic          s1_valid_q;
    logic          s1_sign_q, s1_sign_d;
    logic          s1_nan_q, s1_nan_d;
    logic          s1_inf_q, s1_inf_d;
    logic          s1_zero_q, s1_zero_d;
    logic [PW-1:0] s1_prod_q, s1_prod_d;
    logic [XW-1:0] s1_exp_q, s1_exp_d;

    // Stage 2 registers
    logic             s2_valid_q;
    logic             s2_sign_q, s2_sign_d;
    logic             s2_nan_q, s2_nan_d;
    logic             s2_inf_q, s2_inf_d;
    logic             s2_zero_q, s2_zero_d;
    logic [MAN_W-1:0] s2_frac_q, s2_frac_d;
    logic             s2_guard_q, s2_guard_d;
    logic             s2_sticky_q, s2_sticky_d;
    logic [XW-1:0]    s2_exp_q, s2_exp_d;

    // Output registers
    logic         out_valid_q;
    logic [W-1:0] out_result_q, out_result_d;
    logic         out_nan_q, out_nan_d;
    logic         out_inf_q, out_inf_d;
    logic         out_zero_q, out_zero_d;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_max, b_max;
    logic [MAN_W:0]   frac_rnd;
    logic             round_up;
    logic [XW-1:0]    exp_rnd;
    logic             under, over;

    // The whole pipe advances in lockstep; a stalled output freezes every stage.
    assign in_ready = out_ready | ~out_valid_q;
    assign adv      = in_ready;

    assign ea    = in_a[W-2 -: EXP_W];
    assign eb    = in_b[W-2 -: EXP_W];
    assign fa    = in_a[MAN_W-1:0];
    assign fb    = in_b[MAN_W-1:0];
    assign a_max = (ea == EMAX);
    assign b_max = (eb == EMAX);

    always_comb begin
        s1_sign_d = in_a[W-1] ^ in_b[W-1];
        s1_nan_d  = (a_max & (|fa)) | (b_max & (|fb));
        s1_inf_d  = (a_max & ~(|fa)) | (b_max & ~(|fb));
        s1_zero_d = (ea == '0) | (eb == '0);
        s1_prod_d = PW'({1'b1, fa}) * PW'({1'b1, fb});
        s1_exp_d  = XW'(ea) + XW'(eb) - BIAS;
    end

    always_comb begin
        s2_sign_d = s1_sign_q;
        s2_nan_d  = s1_nan_q | (s1_inf_q & s1_zero_q);
        s2_inf_d  = ~s2_nan_d & s1_inf_q;
        s2_zero_d = ~s2_nan_d & ~s1_inf_q & s1_zero_q;
        if (s1_prod_q[PW-1]) begin
            s2_frac_d   = s1_prod_q[PW-2 -: MAN_W];
            s2_guard_d  = s1_prod_q[MAN_W];
            s2_sticky_d = |s1_prod_q[MAN_W-1:0];
            s2_exp_d    = s1_exp_q + XW'(1);
        end else begin
            s2_frac_d   = s1_prod_q[PW-3 -: MAN_W];
            s2_guard_d  = s1_prod_q[MAN_W-1];
            s2_sticky_d = |s1_prod_q[MAN_W-2:0];
            s2_exp_d    = s1_exp_q;
        end
    end

    // Underflow is judged on the pre-rounding exponent; overflow after the carry.
    always_comb begin
        round_up     = s2_guard_q & (s2_sticky_q | s2_frac_q[0]);
        frac_rnd     = {1'b0, s2_frac_q} + (MAN_W+1)'(round_up);
        exp_rnd      = s2_exp_q + XW'(frac_rnd[MAN_W]);
        under        = s2_exp_q[XW-1] | (s2_exp_q == '0);
        over         = ~exp_rnd[XW-1] & (exp_rnd >= EMAX_X);
        out_result_d = {s2_sign_q, exp_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
        out_nan_d    = 1'b0;
        out_inf_d    = 1'b0;
        out_zero_d   = 1'b0;
        if (s2_nan_q) begin
            out_result_d = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
            out_nan_d    = 1'b1;
        end else if (s2_inf_q) begin
            out_result_d = {s2_sign_q, EMAX, {MAN_W{1'b0}}};
            out_inf_d    = 1'b1;
        end else if (s2_zero_q | under) begin
            out_result_d = {s2_sign_q, {(W-1){1'b0}}};
            out_zero_d   = 1'b1;
        end else if (over) begin
            out_result_d = {s2_sign_q, EMAX, {MAN_W{1'b0}}};
            out_inf_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_prod_q    <= '0;
            s1_exp_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_nan_q     <= 1'b0;
            s2_inf_q     <= 1'b0;
            s2_zero_q    <= 1'b0;
            s2_frac_q    <= '0;
            s2_guard_q   <= 1'b0;
            s2_sticky_q  <= 1'b0;
            s2_exp_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_nan_q    <= 1'b0;
            out_inf_q    <= 1'b0;
            out_zero_q   <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            s1_sign_q   <= s1_sign_d;
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s1_zero_q   <= s1_zero_d;
            s1_prod_q   <= s1_prod_d;
            s1_exp_q    <= s1_exp_d;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s2_sign_d;
            s2_nan_q    <= s2_nan_d;
            s2_inf_q    <= s2_inf_d;
            s2_zero_q   <= s2_zero_d;
            s2_frac_q   <= s2_frac_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
            s2_exp_q    <= s2_exp_d;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_result_q <= out_result_d;
                out_nan_q    <= out_nan_d;
                out_inf_q    <= out_inf_d;
                out_zero_q   <= out_zero_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_nan    = out_nan_q;
    assign out_inf    = out_inf_q;
    assign out_zero   = out_zero_q;
endmodule
